// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two per-port FIFOs drained in program order onto the single RF write port.
// Optional busy scoreboard enabled by defining RF_WB_BUSY_EN; otherwise busy is tied to zero.

module rf_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        push,
  input  logic [4:0]  push_wn,
  input  logic [31:0] push_d,
  input  logic [3:0]  push_stamp,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [4:0]  head_wn,
  output logic [31:0] head_d,
  output logic [3:0]  head_stamp,
  output logic [31:0] busy_vec
);

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
    logic [3:0]  stamp;
  } entry_t;

  entry_t     ent [DEPTH];
  logic [2:0] cnt;
  logic [2:0] wr_idx;

  assign full       = (cnt == 3'(DEPTH));
  assign empty      = (cnt == 3'd0);
  assign wr_idx     = cnt - {2'b0, pop};
  assign head_wn    = ent[0].wn;
  assign head_d     = ent[0].d;
  assign head_stamp = ent[0].stamp;

  // Shift-style queue: entry 0 is always the head, a push lands behind whatever survives the pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 3'(i)) ent[i] <= {push_wn, push_d, push_stamp};
        end
      end
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
    end
  end

`ifdef RF_WB_BUSY_EN
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i) < cnt) busy_vec[ent[i].wn] = 1'b1;
    end
    busy_vec[0] = 1'b0;
  end
`else
  assign busy_vec = '0;
`endif

endmodule

module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        a_valid,
  input  logic [4:0]  a_wn,
  input  logic [31:0] a_d,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wn,
  input  logic [31:0] b_d,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d,
  output logic [31:0] busy
);

  logic        a_full, a_empty, b_full, b_empty;
  logic        a_push, b_push, a_q, b_q;
  logic        grant_a, grant_b;
  logic [3:0]  seq, a_stamp, b_stamp, age;
  logic [4:0]  a_head_wn, b_head_wn;
  logic [31:0] a_head_d, b_head_d;
  logic [3:0]  a_head_stamp, b_head_stamp;
  logic [31:0] a_busy, b_busy;

  assign a_ready = clrn & ~a_full;
  assign b_ready = clrn & ~b_full;
  assign a_push  = a_valid & a_ready;
  assign b_push  = b_valid & b_ready;

  // Writes to r0 complete the handshake but are dropped before queueing and consume no stamp.
  assign a_q     = a_push & (a_wn != 5'd0);
  assign b_q     = b_push & (b_wn != 5'd0);

  // The MEM instruction is older than the EXE one, so B takes the lower stamp on a tie.
  assign b_stamp = seq;
  assign a_stamp = seq + {3'b0, b_q};

  assign age     = a_head_stamp - b_head_stamp;
  assign grant_a = ~a_empty & (b_empty | age[3]);
  assign grant_b = ~b_empty & ~grant_a;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .clrn       (clrn),
    .push       (a_q),
    .push_wn    (a_wn),
    .push_d     (a_d),
    .push_stamp (a_stamp),
    .pop        (grant_a),
    .full       (a_full),
    .empty      (a_empty),
    .head_wn    (a_head_wn),
    .head_d     (a_head_d),
    .head_stamp (a_head_stamp),
    .busy_vec   (a_busy)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .clrn       (clrn),
    .push       (b_q),
    .push_wn    (b_wn),
    .push_d     (b_d),
    .push_stamp (b_stamp),
    .pop        (grant_b),
    .full       (b_full),
    .empty      (b_empty),
    .head_wn    (b_head_wn),
    .head_d     (b_head_d),
    .head_stamp (b_head_stamp),
    .busy_vec   (b_busy)
  );

  assign busy = a_busy | b_busy;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      seq   <= '0;
      rf_we <= 1'b0;
      rf_wn <= '0;
      rf_d  <= '0;
    end else begin
      seq   <= seq + {3'b0, a_q} + {3'b0, b_q};
      rf_we <= grant_a | grant_b;
      if (grant_a) begin
        rf_wn <= a_head_wn;
        rf_d  <= a_head_d;
      end else if (grant_b) begin
        rf_wn <= b_head_wn;
        rf_d  <= b_head_d;
      end
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter for the single write port of the 32x32 register file. Two producers, the EXE-stage ALU result (port A) and the MEM-stage load result (port B), each push writes into a small per-port FIFO. The block drains the FIFOs onto the register-file write port one write per cycle, in strict program order. It also exports a busy scoreboard that the decode stage uses to stall dependent reads.

## Interface
- `DEPTH`, default 2: entries per port FIFO; legal values are 1 to 4.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `clrn` input, 1 bit: asynchronous active-low reset.
- `a_valid` input, 1 bit: ALU write request.
- `a_wn` input, 5 bits: destination register of the ALU write.
- `a_d` input, 32 bits: ALU write data.
- `a_ready` output, 1 bit: port A can accept.
- `b_valid`, `b_wn`, `b_d`, `b_ready`: same as port A, for loads.
- `rf_we` output, 1 bit: register-file write enable (registered).
- `rf_wn` output, 5 bits: register-file write address (registered).
- `rf_d` output, 32 bits: register-file write data (registered).
- `busy` output, 32 bits: bit i is set while a queued, not yet granted write targets register i.

## Operation
- **Handshake**
  - A port transfer occurs when `x_valid & x_ready` at a rising edge.
  - `x_ready = !full(x)`. A same-cycle pop does not free a slot for that cycle's push.
  - Both `x_ready` outputs are 0 while `clrn` is low.
- **Writes to register 0**
  - Accepted with `ready` semantics as normal, then discarded.
  - Not queued, no sequence number consumed, never reach `rf_we`.
- **Sequence stamps**
  - A 4-bit counter `seq` stamps each queued entry.
  - If both ports push in the same cycle, B gets `seq` and A gets `seq+1`, because the MEM instruction is older.
  - `seq` advances by the number of entries queued that cycle, modulo 16.
- **Arbitration** (each cycle, heads only)
  - Neither FIFO non-empty: no grant.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the older head, i.e. A wins iff `(stampA - stampB)` has MSB set (modular compare, mod 16).
  - Outstanding entries never exceed 8, so the compare is unambiguous.
- **Grant**
  - Pops the granted head.
  - Next edge: `rf_we=1`, `rf_wn`/`rf_d` take the head's values.
  - No grant: `rf_we=0`; `rf_wn`/`rf_d` hold their last values.
- **Busy scoreboard**
  - `busy` is the OR over all valid FIFO entries of one-hot(`wn`), combinational from FIFO state.
  - `busy[0]` is always 0.
  - An entry already granted but sitting in the `rf_*` register does not assert `busy`; the register file writes it on the negedge of that same cycle.

## Timing
- Latency: push at edge N → granted during cycle N+1 → `rf_we` high after edge N+1, at the earliest. The register file commits on the following negedge.
- Throughput: one register-file write per cycle. The loser of a both-heads cycle waits at least one cycle.
- Port stall: a port with a full FIFO holds `x_ready` low until its head is popped.
- Reset values:
  - `rf_we=0`, `rf_wn=0`, `rf_d=0`, `busy=0`.
  - `a_ready=b_ready=0` while `clrn` is low, 1 after release.
  - FIFOs empty, `seq=0`.
- Reset asserted mid-operation flushes all queued writes immediately. No `rf_we` pulse follows.

## Configuration
- `RF_WB_BUSY_EN` defined: scoreboard as described above.
- `RF_WB_BUSY_EN` undefined:
  - `busy` is tied to 32'h0.
  - OR-reduction logic is removed.
  - Arbitration, FIFOs and register-file outputs are unchanged.

## Test plan
- **Reset and idle:** hold `clrn=0` with `a_valid=1` → `a_ready=0`, `rf_we=0`, `busy=0`. Release with no requests → `rf_we` stays 0.
- **Single write:** A pushes `wn=5`, `d=32'h12345678` at edge N → `busy[5]=1` during cycle N+1. After edge N+1: `rf_we=1`, `rf_wn=5`, `rf_d=32'h12345678`, `busy[5]=0`.
- **Same-cycle push:** A pushes (3, 32'hAAAA0003) and B pushes (3, 32'hBBBB0003) together → `rf_*` writes B then A on consecutive cycles, so the final value of r3 is 32'hAAAA0003.
- **Register 0 drop:** B pushes `wn=0` → `b_ready` stays 1, `busy` stays 0, no `rf_we` pulse.
- **Full FIFO:** with `DEPTH=2`, A pushes 3 writes back-to-back while B is also streaming and older → `a_ready` low until one of A's entries is granted. No lost or duplicated writes; order matches stamps.
- **Mid-operation reset:** fill both FIFOs, pulse `clrn` low mid-cycle → `busy=0` and `rf_we=0` immediately. No writes after release.
